// File: rtl/port_pin_monitor_if.sv
// ---------------------------------------------------------------------------
// port_pin_monitor_if
// Bundles the pad-side and SFR-side signals of one GPIO port input monitor.
//   master : pad ring / SFR block (drives pad levels and configuration,
//            reads back the filtered level, flags and interrupt request)
//   slave  : port_pin_monitor itself
// Signals:
//   y_portX_i              raw asynchronous pad levels
//   ports_sfr_PXEN_i       direction, 0 = input (edge-capable), 1 = output
//   ports_sfr_PXDB_i       debounce threshold in cycles (0 and 1 = none)
//   ports_sfr_PXIES_i      edge select, 0 = rising, 1 = falling
//   ports_sfr_PXIE_i       per-pin interrupt enable
//   ports_sfr_PXIFG_clr_i  one-cycle write-1-to-clear pulse per flag
//   ports_sfr_PX_o         filtered, synchronised pin level
//   ports_sfr_PXIFG_o      latched edge flags
//   port_irq_o             port interrupt request
// ---------------------------------------------------------------------------
interface port_pin_monitor_if #(
  parameter int WIDTH    = 8,
  parameter int DB_CNT_W = 4
);
  logic [WIDTH-1:0]    y_portX_i;
  logic [WIDTH-1:0]    ports_sfr_PXEN_i;
  logic [DB_CNT_W-1:0] ports_sfr_PXDB_i;
  logic [WIDTH-1:0]    ports_sfr_PXIES_i;
  logic [WIDTH-1:0]    ports_sfr_PXIE_i;
  logic [WIDTH-1:0]    ports_sfr_PXIFG_clr_i;
  logic [WIDTH-1:0]    ports_sfr_PX_o;
  logic [WIDTH-1:0]    ports_sfr_PXIFG_o;
  logic                port_irq_o;

  modport master (
    output y_portX_i, ports_sfr_PXEN_i, ports_sfr_PXDB_i, ports_sfr_PXIES_i,
           ports_sfr_PXIE_i, ports_sfr_PXIFG_clr_i,
    input  ports_sfr_PX_o, ports_sfr_PXIFG_o, port_irq_o
  );

  modport slave (
    input  y_portX_i, ports_sfr_PXEN_i, ports_sfr_PXDB_i, ports_sfr_PXIES_i,
           ports_sfr_PXIE_i, ports_sfr_PXIFG_clr_i,
    output ports_sfr_PX_o, ports_sfr_PXIFG_o, port_irq_o
  );
endinterface

// File: rtl/port_pin_monitor.sv
// ---------------------------------------------------------------------------
// port_pin_monitor
// Input conditioning for one GPIO port: multi-flop synchroniser, per-pin
// debounce with a shared threshold, edge qualification on input pins,
// sticky interrupt flags with write-1-to-clear and a registered port IRQ.
// Ports:
//   clk_i  core clock, all state updates on the rising edge
//   rst_i  synchronous reset, active high
//   pif    port_pin_monitor_if slave modport (pad levels, SFR config in;
//          filtered level, flags, irq out)
// ---------------------------------------------------------------------------
module port_pin_monitor #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  port_pin_monitor_if.slave  pif
);

  // Number of edges after reset release during which the stable level simply
  // tracks the synchroniser output, so the pad state present at reset never
  // shows up as an edge.
  localparam int ARM_LEN = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_LEN + 1);

  logic [WIDTH-1:0]    sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0]    sampled;
  logic [ARM_W-1:0]    arm_cnt_reg;
  logic                armed;
  logic [DB_CNT_W-1:0] thresh_m1;
  logic [WIDTH-1:0]    stable_vec;
  logic [WIDTH-1:0]    edge_vec;
  logic [WIDTH-1:0]    ifg_reg;
  logic [WIDTH-1:0]    ifg_next;
  logic                irq_reg;
  logic                irq_next;

  // Synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= pif.y_portX_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign sampled = sync_reg[SYNC_STAGES-1];

  // Arm counter saturates at ARM_LEN; from then on the block is armed.
  assign armed = (arm_cnt_reg == ARM_W'(ARM_LEN));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_cnt_reg <= '0;
    end else if (!armed) begin
      arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
    end
  end

  // Commit compare value T-1, with T = max(PXDB, 1).
  assign thresh_m1 = (pif.ports_sfr_PXDB_i == '0) ? '0
                   : pif.ports_sfr_PXDB_i - DB_CNT_W'(1);

  // Per-pin debounce and edge detection.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      logic [DB_CNT_W-1:0] cnt_reg;
      logic [DB_CNT_W-1:0] cnt_next;
      logic                stable_reg;
      logic                stable_next;
      logic                commit;

      always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        commit      = 1'b0;
        if (!armed) begin
          stable_next = sampled[gi];
          cnt_next    = '0;
        end else if (sampled[gi] == stable_reg) begin
          cnt_next = '0;
        end else if (cnt_reg >= thresh_m1) begin
          // ">=" so that lowering PXDB below the running count commits on
          // the next differing cycle instead of wrapping the counter.
          stable_next = sampled[gi];
          cnt_next    = '0;
          commit      = 1'b1;
        end else begin
          cnt_next = cnt_reg + DB_CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
        end
      end

      // An edge exists only when the stable level actually changes, so
      // reconfiguring PXIES/PXEN can never fabricate one.
      assign edge_vec[gi] = commit & ~pif.ports_sfr_PXEN_i[gi] &
                            (pif.ports_sfr_PXIES_i[gi] ? ~sampled[gi] : sampled[gi]);
      assign stable_vec[gi] = stable_reg;
    end
  endgenerate

  // Flags: set has priority over a simultaneous clear.
  always_comb begin
    ifg_next = (ifg_reg & ~pif.ports_sfr_PXIFG_clr_i) | edge_vec;
    irq_next = |(ifg_next & pif.ports_sfr_PXIE_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifg_reg <= '0;
      irq_reg <= 1'b0;
    end else begin
      ifg_reg <= ifg_next;
      irq_reg <= irq_next;
    end
  end

  assign pif.ports_sfr_PX_o    = stable_vec;
  assign pif.ports_sfr_PXIFG_o = ifg_reg;
  assign pif.port_irq_o        = irq_reg;

endmodule

// File: tb/tb_port_pin_monitor.sv
// ---------------------------------------------------------------------------
// tb_port_pin_monitor
// Directed bench for port_pin_monitor. A pad-history queue plus run-length
// counters predict the filtered level, flags and irq each cycle; literal
// expectations at key points of each scenario pin both DUT and predictor.
// ---------------------------------------------------------------------------
module tb_port_pin_monitor;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DBW  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  port_pin_monitor_if #(.WIDTH(W), .DB_CNT_W(DBW)) pif ();

  port_pin_monitor #(.WIDTH(W), .SYNC_STAGES(SYNC), .DB_CNT_W(DBW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pif   (pif.slave)
  );

  // ---------------- predictor ----------------
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_px, m_ifg, m_samp, m_edges;
  logic         m_irq;
  int           m_run[W];
  int           m_since;
  int           m_t;
  bit           started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_hist.delete();
      for (int s = 0; s < SYNC; s++) m_hist.push_back('0);
      m_px = '0; m_ifg = '0; m_irq = 1'b0; m_since = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      started = 1;
    end else if (started) begin
      // Level seen by the filter now is the pad level SYNC edges ago.
      m_samp = m_hist.pop_front();
      m_hist.push_back(pif.y_portX_i);
      m_edges = '0;
      m_t = (pif.ports_sfr_PXDB_i == 0) ? 1 : int'(pif.ports_sfr_PXDB_i);
      if (m_since < SYNC + 1) begin
        m_px = m_samp;
        m_since++;
        for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
        for (int i = 0; i < W; i++) begin
          if (m_samp[i] != m_px[i]) begin
            m_run[i]++;
            if (m_run[i] >= m_t) begin
              m_px[i]  = m_samp[i];
              m_run[i] = 0;
              if (!pif.ports_sfr_PXEN_i[i] && (m_samp[i] != pif.ports_sfr_PXIES_i[i]))
                m_edges[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_ifg = (m_ifg & ~pif.ports_sfr_PXIFG_clr_i) | m_edges;
      m_irq = |(m_ifg & pif.ports_sfr_PXIE_i);
    end
    #1;
    if (started) begin
      checks += 3;
      if (pif.ports_sfr_PX_o !== m_px) begin
        errors++;
        $display("FAIL px_cycle t=%0t got %h expected %h", $time, pif.ports_sfr_PX_o, m_px);
      end
      if (pif.ports_sfr_PXIFG_o !== m_ifg) begin
        errors++;
        $display("FAIL ifg_cycle t=%0t got %h expected %h", $time, pif.ports_sfr_PXIFG_o, m_ifg);
      end
      if (pif.port_irq_o !== m_irq) begin
        errors++;
        $display("FAIL irq_cycle t=%0t got %b expected %b", $time, pif.port_irq_o, m_irq);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Compares both the DUT and the predictor against a hand-computed value.
  task automatic check_lit(input string name, input logic [W-1:0] dut_v,
                           input logic [W-1:0] mdl_v, input logic [W-1:0] exp_v);
    checks += 2;
    if (dut_v !== exp_v) begin
      errors++;
      $display("FAIL %s dut got %h expected %h", name, dut_v, exp_v);
    end
    if (mdl_v !== exp_v) begin
      errors++;
      $display("FAIL %s model got %h expected %h", name, mdl_v, exp_v);
    end
  endtask

  task automatic check_state(input string name, input logic [W-1:0] px,
                             input logic [W-1:0] ifg, input logic irq);
    check_lit({name, "_px"},  pif.ports_sfr_PX_o,    m_px,  px);
    check_lit({name, "_ifg"}, pif.ports_sfr_PXIFG_o, m_ifg, ifg);
    check_lit({name, "_irq"}, {7'd0, pif.port_irq_o}, {7'd0, m_irq}, {7'd0, irq});
    $display("txn %s: px=%h ifg=%h irq=%b", name, pif.ports_sfr_PX_o,
             pif.ports_sfr_PXIFG_o, pif.port_irq_o);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    pif.y_portX_i             = 8'hFF;
    pif.ports_sfr_PXEN_i      = 8'h00;
    pif.ports_sfr_PXDB_i      = 4'd0;
    pif.ports_sfr_PXIES_i     = 8'h00;
    pif.ports_sfr_PXIE_i      = 8'h00;
    pif.ports_sfr_PXIFG_clr_i = 8'h00;
    step(2);
    check_state("reset", 8'h00, 8'h00, 1'b0);

    // 1: arm window takes the pad level directly, no flags
    rst = 1'b0;
    step(2);
    check_state("arm_e2", 8'h00, 8'h00, 1'b0);
    step(1);
    check_state("arm_e3", 8'hFF, 8'h00, 1'b0);

    // 2: rising edge on bit0 without debounce
    pif.ports_sfr_PXIE_i = 8'h01;
    pif.y_portX_i = 8'hFE;
    step(4);
    check_state("fall_b0_noflag", 8'hFE, 8'h00, 1'b0);
    pif.y_portX_i = 8'hFF;
    step(2);
    check_state("rise_b0_k1", 8'hFE, 8'h00, 1'b0);
    step(1);
    check_state("rise_b0_k2", 8'hFF, 8'h01, 1'b1);

    // 3: debounce with T=4
    pif.ports_sfr_PXIFG_clr_i = 8'h01;
    step(1);
    pif.ports_sfr_PXIFG_clr_i = 8'h00;
    check_state("clr_b0", 8'hFF, 8'h00, 1'b0);
    pif.ports_sfr_PXDB_i = 4'd4;
    pif.y_portX_i = 8'hF7;
    step(8);
    check_state("db_low_b3", 8'hF7, 8'h00, 1'b0);
    pif.y_portX_i = 8'hFF;
    step(3);
    pif.y_portX_i = 8'hF7;
    step(8);
    check_state("db_pulse3", 8'hF7, 8'h00, 1'b0);
    pif.y_portX_i = 8'hFF;
    step(4);
    pif.y_portX_i = 8'hF7;
    step(1);
    check_state("db_pulse4_e5", 8'hF7, 8'h00, 1'b0);
    step(1);
    check_state("db_pulse4_e6", 8'hFF, 8'h08, 1'b0);
    step(8);
    check_state("db_back_low", 8'hF7, 8'h08, 1'b0);
    pif.ports_sfr_PXIFG_clr_i = 8'h08;
    step(1);
    pif.ports_sfr_PXIFG_clr_i = 8'h00;
    check_state("clr_b3", 8'hF7, 8'h00, 1'b0);

    // 4: masking by PXEN and by the edge select
    pif.ports_sfr_PXDB_i = 4'd0;
    pif.ports_sfr_PXEN_i = 8'h20;
    step(1);
    pif.y_portX_i = 8'hD7;
    step(4);
    check_state("out_pin_low", 8'hD7, 8'h00, 1'b0);
    pif.y_portX_i = 8'hF7;
    step(4);
    check_state("out_pin_high", 8'hF7, 8'h00, 1'b0);
    pif.y_portX_i = 8'hB7;
    step(4);
    pif.ports_sfr_PXIES_i = 8'h40;
    step(1);
    pif.y_portX_i = 8'hF7;
    step(4);
    check_state("ies_mask", 8'hF7, 8'h00, 1'b0);

    // 5: set wins over a simultaneous clear
    pif.ports_sfr_PXIES_i = 8'h00;
    pif.ports_sfr_PXEN_i  = 8'h00;
    pif.y_portX_i = 8'hF6;
    step(4);
    pif.y_portX_i = 8'hF7;
    step(3);
    check_state("flag_b0", 8'hF7, 8'h01, 1'b1);
    pif.y_portX_i = 8'hF6;
    step(4);
    pif.y_portX_i = 8'hF7;
    step(2);
    pif.ports_sfr_PXIFG_clr_i = 8'h01;
    step(1);
    pif.ports_sfr_PXIFG_clr_i = 8'h00;
    check_state("set_over_clr", 8'hF7, 8'h01, 1'b1);
    step(2);
    pif.ports_sfr_PXIFG_clr_i = 8'h01;
    step(1);
    pif.ports_sfr_PXIFG_clr_i = 8'h00;
    check_state("idle_clr", 8'hF7, 8'h00, 1'b0);

    // 6: reset in the middle of a T=8 count
    pif.ports_sfr_PXDB_i = 4'd8;
    step(1);
    pif.y_portX_i = 8'hFF;
    step(6);
    check_state("mid_count", 8'hF7, 8'h00, 1'b0);
    rst = 1'b1;
    step(1);
    check_state("mid_rst", 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(2);
    check_state("rearm_e2", 8'h00, 8'h00, 1'b0);
    step(1);
    check_state("rearm_e3", 8'hFF, 8'h00, 1'b0);
    step(10);
    check_state("rearm_quiet", 8'hFF, 8'h00, 1'b0);

    // 7: lowering PXDB below the running count commits on the next compare
    pif.y_portX_i = 8'hF7;
    step(7);
    check_state("shrink_before", 8'hFF, 8'h00, 1'b0);
    pif.ports_sfr_PXDB_i = 4'd2;
    step(1);
    check_state("shrink_commit", 8'hF7, 8'h00, 1'b0);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
